// File: rtl/ir_receiver.sv
// rtl/ir_receiver.sv - pulse-width IR frame receiver with header, 32 data bits and stop
module ir_receiver #(
  parameter int BASE_DELAY = 250,
  parameter int HDR_MIN    = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx_enable,
  input  logic        rx_port,
  output logic [31:0] rx_data,
  output logic        rx_received,
  output logic        rx_error,
  output logic        rx_busy
);

  typedef enum logic [1:0] {IDLE, HEADER, DATA, STOP_WAIT} state_t;
  typedef enum logic [1:0] {P_ONE, P_ZERO, P_SYNC, P_BAD} pulse_t;

  // Pulse-width class boundaries, all expressed in clock cycles
  localparam logic [11:0] ONE_LO  = 12'(BASE_DELAY / 2);
  localparam logic [11:0] SYNC_LO = 12'((3 * BASE_DELAY) / 2);
  localparam logic [11:0] ZERO_LO = 12'((5 * BASE_DELAY) / 2);
  localparam logic [11:0] ZERO_HI = 12'((7 * BASE_DELAY) / 2);
  localparam logic [11:0] TMO     = 12'(4 * BASE_DELAY);
  localparam logic [5:0]  HDR_REQ = 6'(HDR_MIN);

  logic        sync1, sync2, sync3;
  logic        edge_seen, fall_seen;
  logic [11:0] cnt;
  pulse_t      pulse;

  state_t      state, state_n;
  logic [5:0]  hdr_cnt, hdr_cnt_n;
  logic [4:0]  bit_cnt, bit_cnt_n;
  logic [31:0] shreg, shreg_n;
  logic [31:0] data_n;
  logic        received_n, error_n;

  // Two-flop synchronizer plus one delay flop used only for edge detection
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= rx_port;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign edge_seen = sync2 ^ sync3;
  assign fall_seen = sync3 & ~sync2;

  // Phase-width counter: holds the width of the current phase, restarted at each edge
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (edge_seen) begin
      cnt <= 12'd1;
    end else if (cnt != 12'hFFF) begin
      cnt <= cnt + 12'd1;
    end
  end

  // Classify the high pulse that just ended, valid while fall_seen is high
  always_comb begin
    pulse = P_BAD;
    if (cnt >= ONE_LO && cnt < SYNC_LO) begin
      pulse = P_ONE;
    end else if (cnt >= SYNC_LO && cnt < ZERO_LO) begin
      pulse = P_SYNC;
    end else if (cnt >= ZERO_LO && cnt <= ZERO_HI) begin
      pulse = P_ZERO;
    end
  end

  // Frame state and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      hdr_cnt     <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      rx_data     <= '0;
      rx_received <= 1'b0;
      rx_error    <= 1'b0;
    end else begin
      state       <= state_n;
      hdr_cnt     <= hdr_cnt_n;
      bit_cnt     <= bit_cnt_n;
      shreg       <= shreg_n;
      rx_data     <= data_n;
      rx_received <= received_n;
      rx_error    <= error_n;
    end
  end

  // Next-state decode: disable first, then timeout, then the completed pulse
  always_comb begin
    state_n    = state;
    hdr_cnt_n  = hdr_cnt;
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    data_n     = rx_data;
    received_n = 1'b0;
    error_n    = 1'b0;
    if (!rx_enable) begin
      state_n = IDLE;
    end else if (state != IDLE && !edge_seen && cnt >= TMO) begin
      state_n = IDLE;
      error_n = 1'b1;
    end else if (fall_seen) begin
      case (state)
        IDLE: begin
          if (pulse == P_SYNC) begin
            state_n   = HEADER;
            hdr_cnt_n = 6'd1;
          end
        end
        HEADER: begin
          if (pulse == P_SYNC) begin
            if (hdr_cnt != 6'd63) hdr_cnt_n = hdr_cnt + 6'd1;
          end else if (pulse == P_BAD) begin
            state_n = IDLE;
            error_n = 1'b1;
          end else if (hdr_cnt >= HDR_REQ) begin
            state_n   = DATA;
            shreg_n   = {shreg[30:0], pulse == P_ONE};
            bit_cnt_n = 5'd1;
          end else begin
            state_n = IDLE;
          end
        end
        DATA: begin
          if (pulse == P_ONE || pulse == P_ZERO) begin
            shreg_n   = {shreg[30:0], pulse == P_ONE};
            bit_cnt_n = bit_cnt + 5'd1;
            if (bit_cnt == 5'd31) state_n = STOP_WAIT;
          end else begin
            state_n = IDLE;
            error_n = 1'b1;
          end
        end
        STOP_WAIT: begin
          state_n = IDLE;
          if (pulse == P_SYNC) begin
            data_n     = shreg;
            received_n = 1'b1;
          end else begin
            error_n = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_ir_receiver.sv
// tb/tb_ir_receiver.sv - directed self-checking bench for ir_receiver
`timescale 1ns/1ps
module tb_ir_receiver;

  localparam int T = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic        rx_enable;
  logic        rx_port;
  logic [31:0] rx_data;
  logic        rx_received;
  logic        rx_error;
  logic        rx_busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int recv_cnt = 0;
  int err_cnt  = 0;
  int last_recv_cyc = -1;
  int last_err_cyc  = -1;

  ir_receiver #(.BASE_DELAY(T), .HDR_MIN(16)) dut (
    .clock(clock),
    .reset(reset),
    .rx_enable(rx_enable),
    .rx_port(rx_port),
    .rx_data(rx_data),
    .rx_received(rx_received),
    .rx_error(rx_error),
    .rx_busy(rx_busy)
  );

  always #10 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (rx_received) begin
      recv_cnt++;
      last_recv_cyc = cyc;
    end
    if (rx_error) begin
      err_cnt++;
      last_err_cyc = cyc;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic sym(input int h, input int l);
    rx_port = 1'b1;
    tick(h);
    rx_port = 1'b0;
    tick(l);
  endtask

  task automatic send_header(input int n);
    repeat (n) sym(2 * T, 2 * T);
  endtask

  task automatic send_bits(input logic [31:0] word, input int n);
    for (int i = 31; i > 31 - n; i--) begin
      if (word[i]) sym(T, T);
      else sym(3 * T, 3 * T);
    end
  endtask

  task automatic send_frame(input logic [31:0] word, input int tail);
    send_header(32);
    send_bits(word, 32);
    sym(2 * T, tail);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx_enable = 1'b1;
    rx_port = 1'b0;
    tick(3);
    if (rx_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 00000000", rx_data); end
    n_checks++;
    if (rx_received !== 1'b0) begin n_fail++; $display("FAIL reset_received: got %b expected 0", rx_received); end
    n_checks++;
    if (rx_error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b expected 0", rx_error); end
    n_checks++;
    if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", rx_busy); end
    n_checks++;
    reset = 1'b0;
    tick(3);
  endtask

  task automatic test_basic();
    int r0, e0, c0;
    r0 = recv_cnt;
    e0 = err_cnt;
    send_header(32);
    if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_hdr: got %b expected 1", rx_busy); end
    n_checks++;
    send_bits(32'hBEEF0001, 32);
    rx_port = 1'b1;
    tick(2 * T);
    rx_port = 1'b0;
    c0 = cyc;
    tick(2);
    if (rx_received !== 1'b0) begin n_fail++; $display("FAIL basic_early: got %b expected 0", rx_received); end
    n_checks++;
    tick(1);
    if (rx_received !== 1'b1) begin n_fail++; $display("FAIL basic_pulse: got %b expected 1", rx_received); end
    n_checks++;
    tick(1);
    if (rx_received !== 1'b0) begin n_fail++; $display("FAIL basic_pulse_end: got %b expected 0", rx_received); end
    n_checks++;
    tick(2 * T);
    if (rx_data !== 32'hBEEF0001) begin n_fail++; $display("FAIL basic_data: got %h expected beef0001", rx_data); end
    n_checks++;
    if (recv_cnt - r0 !== 1) begin n_fail++; $display("FAIL basic_recv_count: got %0d expected 1", recv_cnt - r0); end
    n_checks++;
    if (last_recv_cyc !== c0 + 3) begin n_fail++; $display("FAIL basic_latency: got %0d expected %0d", last_recv_cyc - c0, 3); end
    n_checks++;
    if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL basic_err_count: got %0d expected 0", err_cnt - e0); end
    n_checks++;
    if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end: got %b expected 0", rx_busy); end
    n_checks++;
  endtask

  task automatic test_back_to_back();
    int r0, e0;
    r0 = recv_cnt;
    e0 = err_cnt;
    send_frame(32'h00000000, 4);
    if (rx_data !== 32'h00000000) begin n_fail++; $display("FAIL b2b_data0: got %h expected 00000000", rx_data); end
    n_checks++;
    send_frame(32'hFFFFFFFF, 2 * T);
    if (rx_data !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL b2b_data1: got %h expected ffffffff", rx_data); end
    n_checks++;
    if (recv_cnt - r0 !== 2) begin n_fail++; $display("FAIL b2b_recv_count: got %0d expected 2", recv_cnt - r0); end
    n_checks++;
    if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL b2b_err_count: got %0d expected 0", err_cnt - e0); end
    n_checks++;
  endtask

  task automatic test_timeout();
    int e0, r0, c0;
    e0 = err_cnt;
    r0 = recv_cnt;
    send_header(32);
    send_bits(32'hA5000000, 5);
    rx_port = 1'b1;
    c0 = cyc;
    tick(5 * T);
    if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL timeout_err_count: got %0d expected 1", err_cnt - e0); end
    n_checks++;
    if (last_err_cyc !== c0 + 4 * T + 3) begin n_fail++; $display("FAIL timeout_cycle: got %0d expected %0d", last_err_cyc - c0, 4 * T + 3); end
    n_checks++;
    if (rx_data !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL timeout_data: got %h expected ffffffff", rx_data); end
    n_checks++;
    if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL timeout_busy: got %b expected 0", rx_busy); end
    n_checks++;
    rx_port = 1'b0;
    tick(3 * T);
    if (err_cnt - e0 !== 1 || recv_cnt - r0 !== 0) begin n_fail++; $display("FAIL timeout_after: got err %0d recv %0d expected err 1 recv 0", err_cnt - e0, recv_cnt - r0); end
    n_checks++;
  endtask

  task automatic test_glitch();
    int e0;
    e0 = err_cnt;
    send_header(32);
    send_bits(32'h50000000, 4);
    sym(3, 20);
    if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL glitch_data_err: got %0d expected 1", err_cnt - e0); end
    n_checks++;
    if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL glitch_data_busy: got %b expected 0", rx_busy); end
    n_checks++;
    e0 = err_cnt;
    sym(3, 20);
    if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL glitch_idle_err: got %0d expected 0", err_cnt - e0); end
    n_checks++;
    if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL glitch_idle_busy: got %b expected 0", rx_busy); end
    n_checks++;
  endtask

  task automatic test_short_header();
    int e0, r0;
    e0 = err_cnt;
    r0 = recv_cnt;
    send_header(10);
    if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL short_busy_hdr: got %b expected 1", rx_busy); end
    n_checks++;
    send_bits(32'h12345678, 32);
    tick(6 * T);
    if (recv_cnt - r0 !== 0 || err_cnt - e0 !== 0) begin n_fail++; $display("FAIL short_pulses: got recv %0d err %0d expected 0 0", recv_cnt - r0, err_cnt - e0); end
    n_checks++;
    if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL short_busy_end: got %b expected 0", rx_busy); end
    n_checks++;
  endtask

  task automatic test_abort_enable();
    int e0, r0;
    e0 = err_cnt;
    r0 = recv_cnt;
    send_header(32);
    send_bits(32'hCAFEBABE, 16);
    if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL en_busy_mid: got %b expected 1", rx_busy); end
    n_checks++;
    rx_enable = 1'b0;
    tick(1);
    if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL en_busy_off: got %b expected 0", rx_busy); end
    n_checks++;
    tick(3);
    rx_enable = 1'b1;
    tick(3);
    if (recv_cnt - r0 !== 0 || err_cnt - e0 !== 0) begin n_fail++; $display("FAIL en_pulses: got recv %0d err %0d expected 0 0", recv_cnt - r0, err_cnt - e0); end
    n_checks++;
    if (rx_data !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL en_data_hold: got %h expected ffffffff", rx_data); end
    n_checks++;
    send_frame(32'h12345678, 2 * T);
    if (rx_data !== 32'h12345678) begin n_fail++; $display("FAIL en_next_frame: got %h expected 12345678", rx_data); end
    n_checks++;
  endtask

  task automatic test_abort_reset();
    int e0, r0;
    e0 = err_cnt;
    r0 = recv_cnt;
    send_header(32);
    send_bits(32'hCAFEBABE, 16);
    reset = 1'b1;
    tick(1);
    if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", rx_busy); end
    n_checks++;
    if (rx_data !== 32'h0) begin n_fail++; $display("FAIL rst_data: got %h expected 00000000", rx_data); end
    n_checks++;
    reset = 1'b0;
    tick(3);
    if (recv_cnt - r0 !== 0 || err_cnt - e0 !== 0) begin n_fail++; $display("FAIL rst_pulses: got recv %0d err %0d expected 0 0", recv_cnt - r0, err_cnt - e0); end
    n_checks++;
    send_frame(32'h12345678, 2 * T);
    if (rx_data !== 32'h12345678) begin n_fail++; $display("FAIL rst_next_frame: got %h expected 12345678", rx_data); end
    n_checks++;
    if (recv_cnt - r0 !== 1) begin n_fail++; $display("FAIL rst_recv_count: got %0d expected 1", recv_cnt - r0); end
    n_checks++;
  endtask

  initial begin
    reset = 1'b1;
    rx_enable = 1'b0;
    rx_port = 1'b0;
    tick(1);
    test_reset();
    test_basic();
    test_back_to_back();
    test_timeout();
    test_glitch();
    test_short_header();
    test_abort_enable();
    test_abort_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
